gb_timer: RTL and testbench

Memory-mapped DIV/TIMA/TMA/TAC timer. It is the bus responder for the lr35902 initiator's adr/read/write/data protocol.
- Decodes four consecutive addresses starting at BASE_ADR.
- Returns read data on dout with ddrv.
- Commits writes from the CPU's data output.
- Pulses irq on TIMA overflow.
- Sits on the CPU bus beside RAM/IO decode, clocked by the same clk as the CPU.

---
 rtl/gb_io_pkg.sv | 53 +++++
 rtl/gb_bus_target.sv | 55 +++++
 rtl/gb_timer.sv | 185 ++++++++++++++++++
 tb/tb_gb_timer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_io_pkg.sv
// Shared definitions for the memory-mapped IO blocks on the CPU bus.
// Provides bus widths, DIV/TIMA/TMA/TAC register offsets, TAC field constants,
// the TAC clock-select table, the overflow FSM state type and the bus write payload.
package gb_io_pkg;

    localparam int unsigned ADR_W  = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned OFS_W  = 2;
    localparam int unsigned DIV_W  = 16;
    localparam int unsigned TAC_W  = 3;
    localparam int unsigned CNT_W  = 4;

    // Register offsets from the block base address.
    localparam logic [OFS_W-1:0] OFS_DIV  = 2'd0;
    localparam logic [OFS_W-1:0] OFS_TIMA = 2'd1;
    localparam logic [OFS_W-1:0] OFS_TMA  = 2'd2;
    localparam logic [OFS_W-1:0] OFS_TAC  = 2'd3;

    // TAC fields: bit 2 enables the timer, bits 1:0 select the divider tap.
    localparam int unsigned TAC_EN_BIT = 2;

    // Divider tap per TAC[1:0] value.
    localparam logic [3:0] TAC_SEL_BIT_0 = 4'd9;
    localparam logic [3:0] TAC_SEL_BIT_1 = 4'd3;
    localparam logic [3:0] TAC_SEL_BIT_2 = 4'd5;
    localparam logic [3:0] TAC_SEL_BIT_3 = 4'd7;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PEND   = 2'd1,
        RELOAD = 2'd2
    } ovf_state_e;

    // Committed bus write: register offset plus data byte.
    typedef struct packed {
        logic [OFS_W-1:0]  ofs;
        logic [DATA_W-1:0] data;
    } io_wr_t;

    // Timer tick signal: selected divider tap gated by the TAC enable bit.
    function automatic logic tac_tsig(input logic [DIV_W-1:0] divc,
                                      input logic [TAC_W-1:0] tac);
        logic [3:0] idx;
        case (tac[1:0])
            2'd0:    idx = TAC_SEL_BIT_0;
            2'd1:    idx = TAC_SEL_BIT_1;
            2'd2:    idx = TAC_SEL_BIT_2;
            default: idx = TAC_SEL_BIT_3;
        endcase
        return divc[idx] & tac[TAC_EN_BIT];
    endfunction

endpackage

// File: rtl/gb_bus_target.sv
// Generic 4-register bus responder for the lr35902 adr/read/write/data protocol.
// Decodes a 4-byte window at BASE_ADR, gates the read driver and turns each
// write strobe into a single one-clk commit on its rising edge.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   adr, din        CPU address and write data
//   read, write     CPU strobes
//   ddrv            combinational: this block drives the read bus
//   rd_ofs_c        combinational: register offset being read
//   wr_vld_c        combinational: write commits on this clk edge
//   wr_c            combinational: committed write offset and data
module gb_bus_target
    import gb_io_pkg::*;
#(
    parameter logic [ADR_W-1:0] BASE_ADR = 16'hff04
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADR_W-1:0]  adr,
    input  logic [DATA_W-1:0] din,
    input  logic              read,
    input  logic              write,
    output logic              ddrv,
    output logic [OFS_W-1:0]  rd_ofs_c,
    output logic              wr_vld_c,
    output io_wr_t            wr_c
);

    logic sel_c;
    logic write_q;

    // Window match ignores the two offset bits.
    assign sel_c = (adr[ADR_W-1:OFS_W] == BASE_ADR[ADR_W-1:OFS_W]);

    // The CPU samples read data in the same clk, so the read path is unregistered.
    assign ddrv     = read & sel_c;
    assign rd_ofs_c = adr[OFS_W-1:0];

    // Write strobe delayed one clk for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_q <= 1'b0;
        end else begin
            write_q <= write;
        end
    end

    // Exactly one commit per strobe, on its first clk.
    always_comb begin
        wr_vld_c     = write & ~write_q & sel_c;
        wr_c.ofs     = adr[OFS_W-1:0];
        wr_c.data    = din;
    end

endmodule

// File: rtl/gb_timer.sv
// DIV/TIMA/TMA/TAC timer responding on the CPU bus at BASE_ADR..BASE_ADR+3.
// A 16-bit free-running divider feeds a selectable tap; each falling edge of
// the gated tap increments TIMA. A TIMA overflow holds TIMA at zero for
// OVF_DELAY clks, then reloads it from TMA and pulses irq for one clk.
// Build option GB_TIMER_DIV_GLITCH_EN: when defined, DIV/TAC writes that drop
// the gated tap from 1 to 0 cause an extra TIMA increment; when undefined such
// writes never cause increments.
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   adr, din    CPU address and write data
//   read, write CPU strobes
//   dout, ddrv  combinational read data and bus drive enable
//   irq         one-clk timer interrupt pulse
module gb_timer
    import gb_io_pkg::*;
#(
    parameter logic [ADR_W-1:0] BASE_ADR  = 16'hff04,
    parameter int unsigned      OVF_DELAY = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADR_W-1:0]  adr,
    input  logic [DATA_W-1:0] din,
    input  logic              read,
    input  logic              write,
    output logic [DATA_W-1:0] dout,
    output logic              ddrv,
    output logic              irq
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(OVF_DELAY - 1);

    logic [OFS_W-1:0]  rd_ofs_c;
    logic              wr_vld_c;
    io_wr_t            wr_c;

    logic [DIV_W-1:0]  divc;
    logic [DATA_W-1:0] tima;
    logic [DATA_W-1:0] tma;
    logic [TAC_W-1:0]  tac;
    logic              tsig_q;
    ovf_state_e        state;
    logic [CNT_W-1:0]  cnt;

    logic              wr_div;
    logic              wr_tima;
    logic              wr_tma;
    logic              wr_tac;
    logic [DIV_W-1:0]  divc_nxt;
    logic [DATA_W-1:0] tma_nxt;
    logic [TAC_W-1:0]  tac_nxt;
    logic              tsig_c;
    logic              tick_c;
    logic              tsig_q_nxt;
    ovf_state_e        state_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [DATA_W-1:0] tima_nxt;
    logic              irq_nxt;

    gb_bus_target #(
        .BASE_ADR (BASE_ADR)
    ) u_bus (
        .clk      (clk),
        .reset    (reset),
        .adr      (adr),
        .din      (din),
        .read     (read),
        .write    (write),
        .ddrv     (ddrv),
        .rd_ofs_c (rd_ofs_c),
        .wr_vld_c (wr_vld_c),
        .wr_c     (wr_c)
    );

    // Per-register write commits.
    assign wr_div  = wr_vld_c & (wr_c.ofs == OFS_DIV);
    assign wr_tima = wr_vld_c & (wr_c.ofs == OFS_TIMA);
    assign wr_tma  = wr_vld_c & (wr_c.ofs == OFS_TMA);
    assign wr_tac  = wr_vld_c & (wr_c.ofs == OFS_TAC);

    // Divider and configuration next values.
    assign divc_nxt = wr_div ? '0 : divc + DIV_W'(1);
    assign tma_nxt  = wr_tma ? wr_c.data : tma;
    assign tac_nxt  = wr_tac ? wr_c.data[TAC_W-1:0] : tac;

    // Falling edge of the gated divider tap.
    assign tsig_c = tac_tsig(divc, tac);
    assign tick_c = tsig_q & ~tsig_c;

`ifdef GB_TIMER_DIV_GLITCH_EN
    // Edge detector follows the muxed signal, so write-induced drops count.
    assign tsig_q_nxt = tsig_c;
`else
    // Resync the edge detector to post-write values so writes never tick.
    assign tsig_q_nxt = (wr_div | wr_tac) ? tac_tsig(divc_nxt, tac_nxt) : tsig_c;
`endif

    // Overflow FSM and TIMA next value.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tima_nxt  = tima;
        irq_nxt   = 1'b0;
        case (state)
            RUN: begin
                // A CPU write beats a same-clk increment.
                if (wr_tima) begin
                    tima_nxt = wr_c.data;
                end else if (tick_c) begin
                    if (tima == '1) begin
                        tima_nxt  = '0;
                        cnt_nxt   = CNT_LOAD;
                        state_nxt = PEND;
                    end else begin
                        tima_nxt = tima + DATA_W'(1);
                    end
                end
            end
            PEND: begin
                // A TIMA write here cancels the pending reload and interrupt.
                if (wr_tima) begin
                    tima_nxt  = wr_c.data;
                    state_nxt = RUN;
                end else begin
                    if (tick_c) begin
                        tima_nxt = tima + DATA_W'(1);
                    end
                    if (cnt == '0) begin
                        tima_nxt  = tma_nxt;
                        irq_nxt   = 1'b1;
                        state_nxt = RELOAD;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
            end
            RELOAD: begin
                // TIMA tracks TMA for this clk; TIMA writes and ticks are dropped.
                tima_nxt  = tma_nxt;
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // State register for the timer core.
    always_ff @(posedge clk) begin
        if (reset) begin
            divc   <= '0;
            tima   <= '0;
            tma    <= '0;
            tac    <= '0;
            tsig_q <= 1'b0;
            state  <= RUN;
            cnt    <= '0;
            irq    <= 1'b0;
        end else begin
            divc   <= divc_nxt;
            tima   <= tima_nxt;
            tma    <= tma_nxt;
            tac    <= tac_nxt;
            tsig_q <= tsig_q_nxt;
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            irq    <= irq_nxt;
        end
    end

    // Read mux; unused TAC bits read as ones.
    always_comb begin
        dout = '0;
        if (ddrv) begin
            case (rd_ofs_c)
                OFS_DIV:  dout = divc[DIV_W-1:DIV_W-DATA_W];
                OFS_TIMA: dout = tima;
                OFS_TMA:  dout = tma;
                OFS_TAC:  dout = {{(DATA_W-TAC_W){1'b1}}, tac};
                default:  dout = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_gb_timer.sv
`timescale 1ns/1ps
// Self-checking bench for gb_timer: directed scenarios plus random bus traffic
// compared against a behavioural model of the timer registers.
module tb_gb_timer;

    localparam logic [15:0] BASE  = 16'hff04;
    localparam int          OVF_D = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] adr;
    logic [7:0]  din;
    logic        read;
    logic        write;
    logic [7:0]  dout;
    logic        ddrv;
    logic        irq;

    int n_cmp;
    int n_bad;

    gb_timer #(
        .BASE_ADR  (BASE),
        .OVF_DELAY (OVF_D)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .adr   (adr),
        .din   (din),
        .read  (read),
        .write (write),
        .dout  (dout),
        .ddrv  (ddrv),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    // Reference model state: plain integers, overflow tracked as a countdown.
    int m_div, m_tima, m_tma, m_tac, m_ovf_left;
    bit m_reload, m_tsig_prev, m_wprev;
    int sel_bit [4] = '{9, 3, 5, 7};

    logic [7:0] v;
    int found, zeros, got40, r, k, irq_seen;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_tsig(input int d, input int t);
        return ((t & 4) != 0) && (((d >> sel_bit[t & 3]) & 1) != 0);
    endfunction

    // Advance the model by one clk using the inputs present before the edge.
    task automatic model_step();
        bit commit, ts, fall;
        int ofs, n_div, n_tma, n_tac, d;
        if (reset) begin
            m_div = 0; m_tima = 0; m_tma = 0; m_tac = 0;
            m_ovf_left = 0; m_reload = 0; m_tsig_prev = 0; m_wprev = 0;
            return;
        end
        d      = int'(din);
        ofs    = int'(adr) % 4;
        commit = write && !m_wprev && ((int'(adr) / 4) == (int'(BASE) / 4));
        ts     = m_tsig(m_div, m_tac);
        fall   = m_tsig_prev && !ts;
        n_div  = (commit && ofs == 0) ? 0 : (m_div + 1) % 65536;
        n_tma  = (commit && ofs == 2) ? d : m_tma;
        n_tac  = (commit && ofs == 3) ? (d % 8) : m_tac;
        if (m_reload) begin
            m_reload = 0;
            if (commit && ofs == 2) m_tima = d;
        end else if (m_ovf_left > 0) begin
            if (commit && ofs == 1) begin
                m_tima = d;
                m_ovf_left = 0;
            end else begin
                if (fall) m_tima = (m_tima + 1) % 256;
                m_ovf_left--;
                if (m_ovf_left == 0) begin
                    m_tima = n_tma;
                    m_reload = 1;
                end
            end
        end else begin
            if (commit && ofs == 1) m_tima = d;
            else if (fall) begin
                if (m_tima == 255) begin
                    m_tima = 0;
                    m_ovf_left = OVF_D;
                end else begin
                    m_tima++;
                end
            end
        end
`ifdef GB_TIMER_DIV_GLITCH_EN
        m_tsig_prev = ts;
`else
        if (commit && (ofs == 0 || ofs == 3)) m_tsig_prev = m_tsig(n_div, n_tac);
        else m_tsig_prev = ts;
`endif
        m_div = n_div; m_tma = n_tma; m_tac = n_tac; m_wprev = write;
    endtask

    // Expected {ddrv, dout} for the current bus inputs.
    function automatic logic [8:0] m_read();
        if (!read || ((int'(adr) / 4) != (int'(BASE) / 4))) return 9'h000;
        case (int'(adr) % 4)
            0:       return {1'b1, 8'((m_div / 256) % 256)};
            1:       return {1'b1, 8'(m_tima)};
            2:       return {1'b1, 8'(m_tma)};
            default: return {1'b1, 8'(248 + m_tac)};
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check("irq", 16'(irq), 16'(m_reload));
    endtask

    task automatic bus_chk(input string tag);
        logic [8:0] e;
        #1;
        e = m_read();
        check({tag, "_ddrv"}, 16'(ddrv), 16'(e[8]));
        check({tag, "_dout"}, 16'(dout), 16'(e[7:0]));
    endtask

    task automatic rd(input int ofs, input string tag, output logic [7:0] val);
        adr  = BASE + 16'(ofs);
        read = 1'b1;
        bus_chk(tag);
        val  = dout;
        read = 1'b0;
    endtask

    task automatic wr(input int ofs, input logic [7:0] d);
        adr   = BASE + 16'(ofs);
        din   = d;
        write = 1'b1;
        cyc();
        write = 1'b0;
    endtask

    task automatic wrg(input int ofs, input logic [7:0] d);
        wr(ofs, d);
        cyc();
    endtask

    task automatic wait_tima_zero(input string tag);
        found = 0;
        for (int i = 0; i < 64 && found == 0; i++) begin
            cyc();
            rd(1, tag, v);
            if (v == 8'h00) found = 1;
        end
        check({tag, "_seen"}, 16'(found), 16'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_bad = 0;
        reset = 1'b1; read = 1'b0; write = 1'b0; adr = 16'h0000; din = 8'h00;

        // Reset state
        cyc(); cyc();
        bus_chk("rst_idle");
        check("rst_ddrv_const", 16'(ddrv), 16'd0);
        rd(0, "rst_div", v);  check("rst_div_const", 16'(v), 16'h00);
        rd(1, "rst_tima", v); check("rst_tima_const", 16'(v), 16'h00);
        rd(3, "rst_tac", v);  check("rst_tac_const", 16'(v), 16'hf8);
        reset = 1'b0;

        // DIV after 256 clks, and an out-of-window read
        repeat (256) cyc();
        rd(0, "div256", v);
        check("div256_const", 16'(v), 16'h01);
        adr = 16'hff08; read = 1'b1;
        bus_chk("outside");
        check("outside_ddrv_const", 16'(ddrv), 16'd0);
        read = 1'b0;

        // TIMA counting on divider bit 3
        wrg(3, 8'h05);
        wr(1, 8'h00);
        repeat (160) cyc();
        rd(1, "tima160", v);
        check("tima160_const", 16'(v), 16'h0a);

        // Overflow, delayed reload and single irq pulse
        wrg(2, 8'h40);
        wr(1, 8'hff);
        wait_tima_zero("ovf_wait");
        zeros = 1; got40 = 0;
        for (int i = 0; i < 12 && got40 == 0; i++) begin
            cyc();
            rd(1, "ovf_run", v);
            if (v == 8'h00) begin
                zeros++;
                check("ovf_irq_early", 16'(irq), 16'd0);
            end else begin
                got40 = 1;
                check("ovf_reload_val", 16'(v), 16'h40);
                check("ovf_irq_on_reload", 16'(irq), 16'd1);
            end
        end
        check("ovf_zero_clks", 16'(zeros), 16'd4);
        cyc();
        check("ovf_irq_single", 16'(irq), 16'd0);

        // TIMA write during the pending window cancels reload and irq
        wr(1, 8'hff);
        wait_tima_zero("pend_wait");
        wr(1, 8'h12);
        irq_seen = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (irq) irq_seen++;
        end
        check("pend_cancel_irq", 16'(irq_seen), 16'd0);
        rd(1, "pend_cancel", v);
        check("pend_cancel_val", 16'(v), 16'h12);

        // DIV write while the selected tap (bit 9) is high
        wrg(3, 8'h04);
        found = 0;
        for (int i = 0; i < 3000 && found == 0; i++) begin
            if (((m_div / 512) % 2) == 1 && (m_div % 512) < 400) found = 1;
            else cyc();
        end
        check("div9_seen", 16'(found), 16'd1);
        wrg(1, 8'h20);
        wr(0, 8'h9c);
        repeat (3) cyc();
        rd(0, "div_clr", v);
        check("div_clr_const", 16'(v), 16'h00);
        rd(1, "div_glitch", v);
`ifdef GB_TIMER_DIV_GLITCH_EN
        check("div_glitch_const", 16'(v), 16'h21);
`else
        check("div_glitch_const", 16'(v), 16'h20);
`endif

        // Held write commits once; reset mid-overflow aborts cleanly
        adr = BASE + 16'd2; din = 8'h55; write = 1'b1;
        cyc();
        din = 8'haa;
        cyc(); cyc();
        write = 1'b0;
        cyc();
        rd(2, "held_tma", v);
        check("held_tma_const", 16'(v), 16'h55);
        wrg(3, 8'h05);
        wr(1, 8'hff);
        wait_tima_zero("rstp_wait");
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        rd(0, "rstp_div", v);  check("rstp_div_const", 16'(v), 16'h00);
        rd(1, "rstp_tima", v); check("rstp_tima_const", 16'(v), 16'h00);
        rd(2, "rstp_tma", v);  check("rstp_tma_const", 16'(v), 16'h00);
        rd(3, "rstp_tac", v);  check("rstp_tac_const", 16'(v), 16'hf8);
        irq_seen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (irq) irq_seen++;
        end
        check("rstp_no_irq", 16'(irq_seen), 16'd0);

        // Random bus traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            reset = (r == 0) && ($urandom_range(0, 3) == 0);
            if (!write || $urandom_range(0, 2) == 0) begin
                write = ($urandom_range(0, 9) < 2);
                k = int'($urandom_range(0, 9));
                if (k < 8)       adr = BASE + 16'(k % 4);
                else if (k == 8) adr = 16'hff08;
                else             adr = 16'($urandom);
                din = 8'($urandom);
                if (adr == BASE + 16'd1 && $urandom_range(0, 1) == 1) din = 8'hff;
                if (adr == BASE + 16'd3 && $urandom_range(0, 3) != 0) din = din | 8'h04;
            end
            read = 1'($urandom_range(0, 1));
            bus_chk("rnd");
            cyc();
        end
        reset = 1'b0; write = 1'b0; read = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
